// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/execute control for the datapath.
// Fetches 16-bit words from a combinational ROM (address = PC), latches them
// in IR, and steps through one execute sequence per instruction. Datapath
// controls are decoded combinationally from the current state and IR.
// Optional feature macro: SEQ_STEP_EN. When it is defined, the sequencer
// parks in WAIT after every instruction and advances on Step.
module instr_sequencer (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Run,
    input  logic        Step,
    input  logic [15:0] I_rdata,
    output logic [4:0]  I_addr,
    output logic [15:0] IR_Out,
    output logic [3:0]  StateO,
    output logic        Halted,
    output logic [7:0]  D_addr,
    output logic        D_wr,
    output logic        RF_s,
    output logic [3:0]  RF_W_addr,
    output logic        RF_W_wr,
    output logic [3:0]  RF_Ra_addr,
    output logic [3:0]  RF_Rb_addr,
    output logic        RF_Ra_rd,
    output logic        RF_Rb_rd,
    output logic [2:0]  Alu_s0
);

    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_NOOP   = 4'd3,
        ST_LOAD_A = 4'd4,
        ST_LOAD_B = 4'd5,
        ST_STORE  = 4'd6,
        ST_ADD    = 4'd7,
        ST_SUB    = 4'd8,
        ST_HALT   = 4'd9,
        ST_WAIT   = 4'd10
    } state_t;

    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_HALT  = 4'd5;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;

    // Where an execute state goes once the instruction is complete.
`ifdef SEQ_STEP_EN
    localparam state_t ST_AFTER_EXEC = ST_WAIT;
`else
    localparam state_t ST_AFTER_EXEC = ST_FETCH;
`endif

    state_t      state_q, state_d;
    logic [4:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;

    // State, PC and IR registers; reset aborts any instruction immediately.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_INIT;
            pc_q    <= 5'd0;
            ir_q    <= 16'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state logic; FETCH is the only state that loads IR and bumps PC.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            ST_INIT:   state_d = Run ? ST_FETCH : ST_INIT;
            ST_FETCH: begin
                state_d = ST_DECODE;
                ir_d    = I_rdata;
                pc_d    = pc_q + 5'd1;
            end
            ST_DECODE: begin
                case (ir_q[15:12])
                    OP_STORE: state_d = ST_STORE;
                    OP_LOAD:  state_d = ST_LOAD_A;
                    OP_ADD:   state_d = ST_ADD;
                    OP_SUB:   state_d = ST_SUB;
                    OP_HALT:  state_d = ST_HALT;
                    default:  state_d = ST_NOOP;   // NOOP and illegal opcodes
                endcase
            end
            ST_LOAD_A: state_d = ST_LOAD_B;
            ST_NOOP,
            ST_LOAD_B,
            ST_STORE,
            ST_ADD,
            ST_SUB:    state_d = ST_AFTER_EXEC;
            ST_HALT:   state_d = ST_HALT;
            // Only reachable in the single-step build.
            ST_WAIT:   state_d = Step ? ST_FETCH : ST_WAIT;
            default:   state_d = ST_INIT;          // unused encodings recover
        endcase
    end

    // Datapath controls decoded from state and IR; everything idles at 0.
    always_comb begin
        D_addr     = 8'd0;
        D_wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_addr  = 4'd0;
        RF_W_wr    = 1'b0;
        RF_Ra_addr = 4'd0;
        RF_Rb_addr = 4'd0;
        RF_Ra_rd   = 1'b0;
        RF_Rb_rd   = 1'b0;
        Alu_s0     = ALU_PASS;
        case (state_q)
            ST_STORE: begin
                D_addr     = ir_q[11:4];
                RF_Ra_addr = ir_q[3:0];
                RF_Ra_rd   = 1'b1;
                Alu_s0     = ALU_PASS;
                D_wr       = 1'b1;
            end
            ST_LOAD_A: begin
                D_addr    = ir_q[11:4];
                RF_s      = 1'b1;
                RF_W_addr = ir_q[3:0];
            end
            ST_LOAD_B: begin
                // Memory read data has settled; commit it this cycle.
                D_addr    = ir_q[11:4];
                RF_s      = 1'b1;
                RF_W_addr = ir_q[3:0];
                RF_W_wr   = 1'b1;
            end
            ST_ADD,
            ST_SUB: begin
                RF_Ra_addr = ir_q[11:8];
                RF_Rb_addr = ir_q[7:4];
                RF_Ra_rd   = 1'b1;
                RF_Rb_rd   = 1'b1;
                RF_W_addr  = ir_q[3:0];
                RF_s       = 1'b0;
                Alu_s0     = (state_q == ST_ADD) ? ALU_ADD : ALU_SUB;
                RF_W_wr    = 1'b1;
            end
            default: ;
        endcase
    end

    assign I_addr = pc_q;
    assign IR_Out = ir_q;
    assign StateO = state_q;
    assign Halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer. Outputs are sampled on the
// falling edge; inputs change on the falling edge as well.
module tb_instr_sequencer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Run = 1'b0;
    logic        Step = 1'b0;
    logic [15:0] I_rdata;
    logic [4:0]  I_addr;
    logic [15:0] IR_Out;
    logic [3:0]  StateO;
    logic        Halted;
    logic [7:0]  D_addr;
    logic        D_wr;
    logic        RF_s;
    logic [3:0]  RF_W_addr;
    logic        RF_W_wr;
    logic [3:0]  RF_Ra_addr;
    logic [3:0]  RF_Rb_addr;
    logic        RF_Ra_rd;
    logic        RF_Rb_rd;
    logic [2:0]  Alu_s0;

    logic [15:0] rom [0:31];
    int n_checks = 0;
    int n_errors = 0;

`ifdef SEQ_STEP_EN
    localparam int AFTER_EXEC = 10;
`else
    localparam int AFTER_EXEC = 1;
`endif

    assign I_rdata = rom[I_addr];

    always #5 Clk = ~Clk;

    instr_sequencer dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Run        (Run),
        .Step       (Step),
        .I_rdata    (I_rdata),
        .I_addr     (I_addr),
        .IR_Out     (IR_Out),
        .StateO     (StateO),
        .Halted     (Halted),
        .D_addr     (D_addr),
        .D_wr       (D_wr),
        .RF_s       (RF_s),
        .RF_W_addr  (RF_W_addr),
        .RF_W_wr    (RF_W_wr),
        .RF_Ra_addr (RF_Ra_addr),
        .RF_Rb_addr (RF_Rb_addr),
        .RF_Ra_rd   (RF_Ra_rd),
        .RF_Rb_rd   (RF_Rb_rd),
        .Alu_s0     (Alu_s0)
    );

    // Strobe/enable bundle: {D_wr, RF_W_wr, RF_Ra_rd, RF_Rb_rd, RF_s}
    logic [4:0] strobes;
    assign strobes = {D_wr, RF_W_wr, RF_Ra_rd, RF_Rb_rd, RF_s};

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        $display("check %-14s got=%0h exp=%0h", tag, got, exp);
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
    endtask

    // Reset, then pulse Run; returns at the falling edge of the first FETCH.
    task automatic start_prog();
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        Run   = 1'b1;
        @(negedge Clk);
        Run   = 1'b0;
    endtask

    // Leave an execute state; in the step build issue one Step pulse.
    task automatic to_next_fetch(input string tag);
        @(negedge Clk);
        check_val({tag, "_post"}, StateO, AFTER_EXEC);
`ifdef SEQ_STEP_EN
        Step = 1'b1;
        @(negedge Clk);
        Step = 1'b0;
`endif
    endtask

    initial begin
        clear_rom();

        // Reset values
        @(negedge Clk);
        check_val("rst_state", StateO, 0);
        check_val("rst_pc", I_addr, 0);
        check_val("rst_ir", IR_Out, 0);
        check_val("rst_halt", Halted, 0);
        check_val("rst_strobe", strobes, 0);
        check_val("rst_addrs", {D_addr, RF_W_addr, RF_Ra_addr, RF_Rb_addr, Alu_s0}, 0);
        Reset = 1'b0;
        @(negedge Clk);
        check_val("init_idle", StateO, 0);

        // NOOP then HALT
        rom[1] = 16'h5000;
        start_prog();
        check_val("t1_c1", StateO, 1);
        @(negedge Clk); check_val("t1_c2", StateO, 2);
        @(negedge Clk); check_val("t1_c3", StateO, 3);
        to_next_fetch("t1");
        check_val("t1_c4", StateO, 1);
        @(negedge Clk); check_val("t1_c5", StateO, 2);
        @(negedge Clk); check_val("t1_c6", StateO, 9);
        check_val("t1_halted", Halted, 1);
        check_val("t1_pc", I_addr, 2);
        Run = 1'b1;
        repeat (3) @(negedge Clk);
        Run = 1'b0;
        check_val("t1_hold_st", StateO, 9);
        check_val("t1_hold_pc", I_addr, 2);
        check_val("t1_hold_ir", IR_Out, 16'h5000);
        check_val("t1_hold_hlt", Halted, 1);

        // LOAD mem[0x05] -> R3
        clear_rom();
        rom[0] = 16'h2053;
        start_prog();
        @(negedge Clk); check_val("ld_ir", IR_Out, 16'h2053);
        @(negedge Clk);
        check_val("ld_a_state", StateO, 4);
        check_val("ld_a_strobe", strobes, 5'b00001);
        check_val("ld_a_daddr", D_addr, 8'h05);
        check_val("ld_a_waddr", RF_W_addr, 3);
        @(negedge Clk);
        check_val("ld_b_state", StateO, 5);
        check_val("ld_b_strobe", strobes, 5'b01001);
        check_val("ld_b_waddr", RF_W_addr, 3);
        check_val("ld_b_daddr", D_addr, 8'h05);
        to_next_fetch("ld");
        check_val("ld_next_wr", RF_W_wr, 0);

        // ADD R6 = R1 + R2
        rom[0] = 16'h3126;
        start_prog();
        repeat (2) @(negedge Clk);
        check_val("add_state", StateO, 7);
        check_val("add_ra", RF_Ra_addr, 1);
        check_val("add_rb", RF_Rb_addr, 2);
        check_val("add_wa", RF_W_addr, 6);
        check_val("add_alu", Alu_s0, 1);
        check_val("add_strobe", strobes, 5'b01110);
        to_next_fetch("add");
        check_val("add_next_wr", RF_W_wr, 0);

        // SUB R6 = R1 - R2
        rom[0] = 16'h4126;
        start_prog();
        repeat (2) @(negedge Clk);
        check_val("sub_state", StateO, 8);
        check_val("sub_ra", RF_Ra_addr, 1);
        check_val("sub_rb", RF_Rb_addr, 2);
        check_val("sub_wa", RF_W_addr, 6);
        check_val("sub_alu", Alu_s0, 2);
        check_val("sub_strobe", strobes, 5'b01110);

        // STORE R7 -> mem[0xA0]
        rom[0] = 16'h1A07;
        start_prog();
        repeat (2) @(negedge Clk);
        check_val("st_state", StateO, 6);
        check_val("st_daddr", D_addr, 8'hA0);
        check_val("st_ra", RF_Ra_addr, 7);
        check_val("st_alu", Alu_s0, 0);
        check_val("st_strobe", strobes, 5'b10100);
        to_next_fetch("st");
        check_val("st_next_dwr", D_wr, 0);

        // Illegal opcode 0xF executes as NOOP
        rom[0] = 16'hF123;
        start_prog();
        repeat (2) @(negedge Clk);
        check_val("ill_state", StateO, 3);
        check_val("ill_strobe", strobes, 0);
        check_val("ill_daddr", D_addr, 0);

        // PC wrap: 32 NOOPs, then ROM[0] fetched again
        clear_rom();
        rom[0] = 16'h0F00;
        Step = 1'b1;            // no effect in the default build
        start_prog();
        for (int i = 0; i < 32; i++) begin
            if (StateO !== 4'd1 || I_addr !== 5'(i))
                check_val($sformatf("wrap_pc%0d", i), {StateO, 3'b0, I_addr}, {4'd1, 3'b0, 5'(i)});
`ifdef SEQ_STEP_EN
            repeat (4) @(negedge Clk);
`else
            repeat (3) @(negedge Clk);
`endif
        end
        check_val("wrap_state", StateO, 1);
        check_val("wrap_pc", I_addr, 0);
        @(negedge Clk);
        check_val("wrap_ir", IR_Out, 16'h0F00);
        Step = 1'b0;

        // Asynchronous reset in the middle of LOAD_A
        rom[0] = 16'h2053;
        start_prog();
        repeat (2) @(negedge Clk);
        check_val("ar_pre_state", StateO, 4);
        #1 Reset = 1'b1;
        #1;
        check_val("ar_state", StateO, 0);
        check_val("ar_strobe", strobes, 0);
        check_val("ar_pc", I_addr, 0);
        check_val("ar_ir", IR_Out, 0);
        check_val("ar_addrs", {D_addr, RF_W_addr, RF_Ra_addr, RF_Rb_addr, Alu_s0}, 0);
        @(negedge Clk);
        Reset = 1'b0;

`ifdef SEQ_STEP_EN
        // Parking in WAIT and single-step pulse
        clear_rom();
        start_prog();
        repeat (2) @(negedge Clk);
        check_val("stp_noop", StateO, 3);
        repeat (4) @(negedge Clk);
        check_val("stp_wait", StateO, 10);
        check_val("stp_wait_str", strobes, 0);
        Step = 1'b1;
        @(negedge Clk);
        Step = 1'b0;
        check_val("stp_fetch", StateO, 1);
        check_val("stp_pc", I_addr, 1);
        repeat (3) @(negedge Clk);
        check_val("stp_wait2", StateO, 10);
        check_val("stp_pc2", I_addr, 2);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle instruction sequencer that drives the processor datapath's register-file, data-memory and ALU control inputs. It fetches 16-bit instructions from a combinational instruction ROM addressed by a 5-bit PC and decodes them. Each instruction then executes through a fixed state sequence, with one write strobe per instruction. It sits between the instruction ROM and the datapath and replaces hand-sequenced control in the processor top level.

## Interface
- No parameters. Widths are fixed by the datapath.
- Clk  in  1  system clock, rising-edge.
- Reset  in  1  asynchronous, active-high. Clears PC, IR and state.
- Run  in  1  start strobe. Sampled only in INIT.
- Step  in  1  single-step advance. Used only with SEQ_STEP_EN.
- I_rdata  in  16  instruction ROM data at I_addr (combinational ROM).
- I_addr  out  5  ROM address. Equals the PC.
- IR_Out  out  16  instruction register.
- StateO  out  4  current state encoding.
- Halted  out  1  high in HALT.
- D_addr  out  8  data memory address.
- D_wr  out  1  data memory write strobe.
- RF_s  out  1  RF write-data mux select: 1 = memory, 0 = ALU.
- RF_W_addr  out  4  RF write address.
- RF_W_wr  out  1  RF write strobe.
- RF_Ra_addr / RF_Rb_addr  out  4 each  RF read addresses.
- RF_Ra_rd / RF_Rb_rd  out  1 each  RF read enables.
- Alu_s0  out  3  ALU function: 0 = pass A, 1 = A+B, 2 = A−B.

## Operation
- Instruction opcode is IR[15:12]:
  - 0 NOOP.
  - 1 STORE: mem[IR[11:4]] ← RF[IR[3:0]].
  - 2 LOAD: RF[IR[3:0]] ← mem[IR[11:4]].
  - 3 ADD: RF[IR[3:0]] ← RF[IR[11:8]] + RF[IR[7:4]].
  - 4 SUB: same fields as ADD, computing A − B.
  - 5 HALT.
  - 6–15: illegal, executed as NOOP.
- States and StateO encodings: INIT=0, FETCH=1, DECODE=2, NOOP=3, LOAD_A=4, LOAD_B=5, STORE=6, ADD=7, SUB=8, HALT=9, WAIT=10. Codes 11–15 are unreachable; if entered, go to INIT.
- Transitions:
  - INIT→FETCH when Run=1; otherwise stay in INIT.
  - FETCH→DECODE, with IR←I_rdata and PC←PC+1.
  - DECODE→the execute state selected by the opcode.
  - LOAD_A→LOAD_B.
  - NOOP, LOAD_B, STORE, ADD and SUB go to FETCH (or WAIT with SEQ_STEP_EN).
  - HALT stays in HALT until Reset.
- PC is 5 bits and wraps 31→0.
- Outputs are combinational from state and IR. All strobes and read enables are 0 outside the states listed below; addresses and Alu_s0 are 0 when not used.
  - STORE: D_addr=IR[11:4], RF_Ra_addr=IR[3:0], RF_Ra_rd=1, Alu_s0=0, D_wr=1.
  - LOAD_A: D_addr=IR[11:4], RF_s=1, RF_W_addr=IR[3:0]. No write.
  - LOAD_B: same outputs as LOAD_A, plus RF_W_wr=1.
  - ADD/SUB: Ra=IR[11:8], Rb=IR[7:4], both read enables=1, RF_W_addr=IR[3:0], RF_s=0, Alu_s0=1 (ADD) or 2 (SUB), RF_W_wr=1.
- Each write strobe (D_wr or RF_W_wr) is high for exactly one cycle per instruction.

## Timing
- Reset values: PC=0, IR_Out=0, StateO=0, Halted=0, all strobes 0, all addresses 0, Alu_s0=0.
- Reset assertion is asynchronous and aborts any instruction immediately; a pending write strobe drops in the same cycle.
- Cycles per instruction, counted from entry to FETCH: NOOP, STORE, ADD, SUB, HALT and illegal = 3; LOAD = 4.
- The first FETCH occurs in the cycle after the edge that samples Run=1 in INIT. Run is ignored in every other state.
- Halted rises on entry to HALT and holds until Reset. In HALT, PC holds and IR holds the HALT word.
- Simultaneous Run and Reset: Reset wins.

## Configuration
- Macro SEQ_STEP_EN.
- Defined:
  - After each execute-state completion, go to WAIT instead of FETCH.
  - WAIT→FETCH on a cycle with Step=1; WAIT holds while Step=0.
  - Step is level-sampled; holding Step high runs continuously with 4/5-cycle instructions.
  - All strobes are 0 in WAIT.
- Undefined: WAIT is unreachable and Step is ignored.

## Test plan
- Reset then Run=1 with ROM[0]=0x0000, ROM[1]=0x5000 → StateO 1,2,3,1,2,9; Halted=1; I_addr=2 and holds.
- ROM[0]=0x2053 (LOAD mem[0x05]→R3) → cycle 3: StateO=4, RF_s=1, RF_W_wr=0, D_addr=0x05. Cycle 4: RF_W_wr=1, RF_W_addr=3.
- ROM[0]=0x3126 (ADD R6=R1+R2) and 0x4126 (SUB) → single cycle with RF_Ra_addr=1, RF_Rb_addr=2, RF_W_addr=6, Alu_s0=1/2, RF_W_wr=1.
- ROM[0]=0x1A07 (STORE R7→mem[0xA0]) → D_wr=1 for one cycle, D_addr=0xA0, RF_Ra_addr=7. Opcode 0xF → behaves as NOOP, StateO=3.
- 32 NOOPs with no HALT → PC wraps 31→0 and fetches ROM[0] again. Reset asserted mid-LOAD_A → all outputs 0 and StateO=0 before the next edge.
- With SEQ_STEP_EN, Step=0 → sequencer parks in WAIT (StateO=10). A one-cycle Step pulse executes exactly one instruction.
